// File: rtl/uart_matrix_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_matrix_loader_pkg
//  Brief    : Shared state encodings, matrix selectors and frame sizing.
//  Revision : 1.0
// ============================================================================
package uart_matrix_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WAIT   = 3'd1,
        ST_WRITE  = 3'd2,
        ST_CHECK  = 3'd3,
        ST_FINISH = 3'd4
    } state_t;

    localparam logic [1:0] MAT_A = 2'd0;
    localparam logic [1:0] MAT_B = 2'd1;
    localparam logic [1:0] MAT_C = 2'd2;

    function automatic int frame_len(input int dim, input int n_mat);
        return dim * dim * n_mat;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_matrix_loader_rx_pulse_sync.sv
`default_nettype none
// ============================================================================
//  Module   : uart_matrix_loader_rx_pulse_sync
//  Brief    : rx_ready synchroniser plus registered rising-edge pulse (rx_evt).
//  Revision : 1.0
// ============================================================================
module uart_matrix_loader_rx_pulse_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic rx_ready,
    output logic rx_evt
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic                   r_evt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync <= '0;
            r_prev <= 1'b0;
            r_evt  <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], rx_ready};
            r_prev <= r_sync[SYNC_STAGES-1];
            r_evt  <= r_sync[SYNC_STAGES-1] & ~r_prev;
        end
    end

    assign rx_evt = r_evt;

endmodule
`default_nettype wire

// File: rtl/uart_matrix_loader.sv
`default_nettype none
// ============================================================================
//  Module   : uart_matrix_loader
//  Brief    : Writes UART bytes row-major into memory as matrix A then B and
//             pulses mac_start. Optional frame checksum under `CKSUM_EN.
//  Revision : 1.0
// ============================================================================
module uart_matrix_loader
    import uart_matrix_loader_pkg::*;
#(
    parameter int DIM         = 3,
    parameter int N_MAT       = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] rx_byte,
    input  logic       rx_ready,
    output logic       mem_own,
    output logic       write_enable,
    output logic [7:0] write_data,
    output logic [1:0] matrix_select,
    output logic [1:0] row,
    output logic [1:0] col,
    output logic       mac_start,
    output logic       load_done,
    output logic       overrun,
    output logic       cksum_err
);

    localparam int               c_frame_len = frame_len(DIM, N_MAT);
    localparam int               c_cnt_w     = $clog2(c_frame_len + 1);
    localparam logic [c_cnt_w-1:0] c_last_cnt = c_cnt_w'(c_frame_len - 1);
    localparam logic [1:0]       c_last_idx  = 2'(DIM - 1);
    // Matrix C is reserved for results, so at most A and B are ever loaded.
    localparam logic [1:0]       c_last_mat  = (N_MAT > 1) ? MAT_B : MAT_A;

    state_t               r_state;
    state_t               w_next;
    logic                 w_rx_evt;
    logic [7:0]           r_byte;
    logic [1:0]           r_mat;
    logic [1:0]           r_row;
    logic [1:0]           r_col;
    logic [c_cnt_w-1:0]   r_count;
    logic                 r_overrun;
    logic                 w_last;

    uart_matrix_loader_rx_pulse_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_rx_sync (
        .clk      (clk),
        .reset    (reset),
        .rx_ready (rx_ready),
        .rx_evt   (w_rx_evt)
    );

    assign w_last = (r_count == c_last_cnt);

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (start)    w_next = ST_WAIT;
            ST_WAIT:   if (w_rx_evt) w_next = ST_WRITE;
`ifdef CKSUM_EN
            ST_WRITE:  w_next = w_last ? ST_CHECK : ST_WAIT;
            ST_CHECK:  if (w_rx_evt) w_next = ST_FINISH;
`else
            ST_WRITE:  w_next = w_last ? ST_FINISH : ST_WAIT;
`endif
            ST_FINISH: w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

`ifdef CKSUM_EN
    logic [7:0] r_cksum;
    logic       r_cksum_err;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_byte    <= 8'd0;
            r_mat     <= MAT_A;
            r_row     <= 2'd0;
            r_col     <= 2'd0;
            r_count   <= '0;
            r_overrun <= 1'b0;
`ifdef CKSUM_EN
            r_cksum     <= 8'd0;
            r_cksum_err <= 1'b0;
`endif
        end else begin
            r_state <= w_next;
            if (w_rx_evt) r_byte <= rx_byte;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_mat     <= MAT_A;
                        r_row     <= 2'd0;
                        r_col     <= 2'd0;
                        r_count   <= '0;
                        r_overrun <= 1'b0;
`ifdef CKSUM_EN
                        r_cksum     <= 8'd0;
                        r_cksum_err <= 1'b0;
`endif
                    end
                end
                ST_WRITE: begin
                    if (w_rx_evt) r_overrun <= 1'b1;
                    r_count <= w_last ? '0 : r_count + 1'b1;
                    if (r_col == c_last_idx) begin
                        r_col <= 2'd0;
                        if (r_row == c_last_idx) begin
                            r_row <= 2'd0;
                            r_mat <= (r_mat == c_last_mat) ? MAT_A : r_mat + 2'd1;
                        end else begin
                            r_row <= r_row + 2'd1;
                        end
                    end else begin
                        r_col <= r_col + 2'd1;
                    end
`ifdef CKSUM_EN
                    r_cksum <= r_cksum + r_byte;
`endif
                end
`ifdef CKSUM_EN
                // The byte arriving in CHECK is the checksum itself, not an overrun.
                ST_CHECK: begin
                    if (w_rx_evt) r_cksum_err <= (rx_byte != r_cksum);
                end
`endif
                ST_FINISH: begin
                    if (w_rx_evt) r_overrun <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign mem_own       = (r_state != ST_IDLE);
    assign write_enable  = (r_state == ST_WRITE);
    assign write_data    = write_enable ? r_byte : 8'd0;
    assign matrix_select = r_mat;
    assign row           = r_row;
    assign col           = r_col;
    assign load_done     = (r_state == ST_FINISH);
    assign overrun       = r_overrun;
`ifdef CKSUM_EN
    assign mac_start     = (r_state == ST_FINISH) && !r_cksum_err;
    assign cksum_err     = r_cksum_err;
`else
    assign mac_start     = (r_state == ST_FINISH);
    assign cksum_err     = 1'b0;
`endif

endmodule
`default_nettype wire
